// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES-192 job arbiter and related shared-engine front ends.
package aes_arb_pkg;

    localparam int AES_BLK_W = 128;
    localparam logic [1:0] KEY_SEL_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    function automatic logic key_sel_legal(input logic [1:0] key_sel);
        return key_sel != KEY_SEL_ILLEGAL;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first eligible index at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [ID_W-1:0]  i_ptr,
    input  logic [N_REQ-1:0] i_eligible,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    int w_best_rank;

    // Rank each requester by its distance from the pointer; the lowest-ranked eligible one wins.
    always_comb begin
        o_idx       = '0;
        o_any       = 1'b0;
        w_best_rank = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_eligible[i] && (((i - int'(i_ptr)) + N_REQ) % N_REQ) < w_best_rank) begin
                w_best_rank = ((i - int'(i_ptr)) + N_REQ) % N_REQ;
                o_idx       = ID_W'(i);
                o_any       = 1'b1;
            end
        end
    end

    assign o_grant = o_any ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/aes192_job_arbiter.sv
// Shares one AES-192 engine among N_REQ requesters: round-robin grant, one job in flight,
// start pulse sequencing, watchdog on the completion edge, and an id-tagged response.
module aes192_job_arbiter
    import aes_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_valid_i,
    output logic [N_REQ-1:0]           req_ready_o,
    input  logic [N_REQ*AES_BLK_W-1:0] req_pt_i,
    input  logic [N_REQ*AES_BLK_W-1:0] req_state_i,
    input  logic [N_REQ*2-1:0]         req_key_sel_i,
    input  logic [N_REQ-1:0]           req_mask_i,
    output logic                       aes_start_o,
    output logic [AES_BLK_W-1:0]       aes_pt_o,
    output logic [AES_BLK_W-1:0]       aes_state_o,
    output logic [1:0]                 aes_key_sel_o,
    input  logic [AES_BLK_W-1:0]       aes_ct_i,
    input  logic                       aes_ct_valid_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [ID_W-1:0]            rsp_id_o,
    output logic [AES_BLK_W-1:0]       rsp_ct_o,
    output logic                       rsp_err_o,
    output logic                       busy_o
);

    localparam int WD_W = $clog2(TIMEOUT) + 1;

    arb_state_e r_state;
    arb_state_e w_state_next;

    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_id;
    logic [AES_BLK_W-1:0] r_pt;
    logic [AES_BLK_W-1:0] r_st;
    logic [1:0]           r_key;
    logic [AES_BLK_W-1:0] r_ct;
    logic                 r_err;
    logic                 r_ct_valid_q;
    logic [WD_W-1:0]      r_wdog;

    logic [N_REQ-1:0]     w_eligible;
    logic [N_REQ-1:0]     w_grant;
    logic [ID_W-1:0]      w_idx;
    logic                 w_any;
    logic [ID_W-1:0]      w_ptr_next;
    logic [AES_BLK_W-1:0] w_sel_pt;
    logic [AES_BLK_W-1:0] w_sel_st;
    logic [1:0]           w_sel_key;
    logic                 w_complete;
    logic                 w_timeout;

    assign w_eligible = req_valid_i & ~req_mask_i;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .i_ptr      (r_ptr),
        .i_eligible (w_eligible),
        .o_grant    (w_grant),
        .o_idx      (w_idx),
        .o_any      (w_any)
    );

    always_comb begin
        w_sel_pt  = '0;
        w_sel_st  = '0;
        w_sel_key = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_pt  = req_pt_i[i*AES_BLK_W +: AES_BLK_W];
                w_sel_st  = req_state_i[i*AES_BLK_W +: AES_BLK_W];
                w_sel_key = req_key_sel_i[i*2 +: 2];
            end
        end
    end

    assign w_ptr_next = (int'(w_idx) == N_REQ - 1) ? '0 : w_idx + 1'b1;
    // Only a fresh rising edge completes a job, so a level left high by an earlier job is ignored.
    assign w_complete = aes_ct_valid_i & ~r_ct_valid_q;
    assign w_timeout  = (r_wdog == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        req_ready_o   = '0;
        aes_start_o   = 1'b0;
        aes_pt_o      = '0;
        aes_state_o   = '0;
        aes_key_sel_o = '0;
        rsp_valid_o   = 1'b0;
        rsp_id_o      = '0;
        rsp_ct_o      = '0;
        rsp_err_o     = 1'b0;
        busy_o        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (w_any) begin
                    req_ready_o  = w_grant;
                    w_state_next = key_sel_legal(w_sel_key) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                aes_start_o   = 1'b1;
                aes_pt_o      = r_pt;
                aes_state_o   = r_st;
                aes_key_sel_o = r_key;
                w_state_next  = ST_WAIT;
            end
            ST_WAIT: begin
                aes_pt_o      = r_pt;
                aes_state_o   = r_st;
                aes_key_sel_o = r_key;
                if (w_complete || w_timeout) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_id_o    = r_id;
                rsp_ct_o    = r_ct;
                rsp_err_o   = r_err;
                if (rsp_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Job capture, result capture and watchdog; the edge detector runs every cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_pt         <= '0;
            r_st         <= '0;
            r_key        <= '0;
            r_ct         <= '0;
            r_err        <= 1'b0;
            r_ct_valid_q <= 1'b0;
            r_wdog       <= '0;
        end else begin
            r_ct_valid_q <= aes_ct_valid_i;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id  <= w_idx;
                        r_pt  <= w_sel_pt;
                        r_st  <= w_sel_st;
                        r_key <= w_sel_key;
                        r_ptr <= w_ptr_next;
                        r_ct  <= '0;
                        r_err <= ~key_sel_legal(w_sel_key);
                    end
                end
                ST_ISSUE: begin
                    r_wdog <= '0;
                end
                ST_WAIT: begin
                    if (w_complete) begin
                        r_ct  <= aes_ct_i;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_ct  <= '0;
                        r_err <= 1'b1;
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
